// File: rtl/if_stage_pkg.sv
// Shared encodings for the fetch stage: next-PC selects, FSM states, NOP bubble.
// No logic, constants only.
// Imported by if_stage and pc_target_calc.
package if_stage_pkg;

    localparam logic [1:0] PC_NEXT   = 2'd0;
    localparam logic [1:0] PC_JUMP   = 2'd1;
    localparam logic [1:0] PC_BRANCH = 2'd2;
    localparam logic [1:0] PC_JR     = 2'd3;

    localparam logic [1:0] ST_REQ  = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    localparam logic [31:0] INST_NOP = 32'h0000_0000;

endpackage

// File: rtl/if_stage_pc_target_calc.sv
// Redirect target for the instruction sitting in ID (branch, jump, jump-register).
// Purely combinational, zero latency.
// No flow control; the result is consumed only when the controller redirects.
module pc_target_calc
    import if_stage_pkg::*;
(
    input  logic [31:0] inst_id,
    input  logic [31:0] pc_id,
    input  logic [31:0] rs_data_id,
    input  logic [1:0]  pc_src,
    output logic [31:0] target
);

    logic [31:0] pc_plus4;
    logic [31:0] br_off;

    assign pc_plus4 = pc_id + 32'd4;
    assign br_off   = {{14{inst_id[15]}}, inst_id[15:0], 2'b00};

    always_comb begin
        target = pc_plus4;
        case (pc_src)
            PC_BRANCH: target = pc_plus4 + br_off;
            PC_JUMP:   target = {pc_plus4[31:28], inst_id[25:0], 2'b00};
            PC_JR:     target = {rs_data_id[31:2], 2'b00};
            default:   target = pc_plus4;
        endcase
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: owns the PC, drives the req/ack imem port, loads IF/ID.
// Zero-wait memory yields one instruction per cycle; redirect target requested next cycle.
// if_en=0 stalls PC and IF/ID; a late ack parks data in hold_inst until the stall lifts.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_rst,
    input  logic        if_en,
    input  logic [1:0]  pc_src,
    input  logic [31:0] rs_data_id,
    output logic        inst_ren,
    output logic [31:0] inst_addr,
    input  logic        inst_ack,
    input  logic [31:0] inst_data,
    output logic [31:0] inst_id,
    output logic [31:0] pc_id,
    output logic        id_valid,
    output logic        if_valid
);

    logic [1:0]  state;
    logic [31:0] pc;
    logic [31:0] pend_pc;
    logic [31:0] hold_inst;
    logic [31:0] target;
    logic        redirect;

    pc_target_calc u_pc_target_calc (
        .inst_id    (inst_id),
        .pc_id      (pc_id),
        .rs_data_id (rs_data_id),
        .pc_src     (pc_src),
        .target     (target)
    );

    assign redirect  = if_en & id_valid & (pc_src != PC_NEXT);
    assign inst_ren  = (state != ST_HOLD);
    assign inst_addr = pc;
    assign if_valid  = (state != ST_DROP);

    always_ff @(posedge clk) begin
        if (rst || if_rst) begin
            state     <= ST_REQ;
            pc        <= RESET_PC;
            pend_pc   <= '0;
            hold_inst <= '0;
            inst_id   <= INST_NOP;
            pc_id     <= '0;
            id_valid  <= 1'b0;
        end else begin
            case (state)
                ST_REQ: begin
                    if (inst_ack) begin
                        if (redirect) begin
                            pc       <= target;
                            inst_id  <= INST_NOP;
                            pc_id    <= '0;
                            id_valid <= 1'b0;
                        end else if (if_en) begin
                            inst_id  <= inst_data;
                            pc_id    <= pc;
                            id_valid <= 1'b1;
                            pc       <= pc + 32'd4;
                        end else begin
                            hold_inst <= inst_data;
                            state     <= ST_HOLD;
                        end
                    end else if (redirect) begin
                        // The request is still in flight, so the address must not move
                        // until it completes; remember where to go afterwards.
                        pend_pc  <= target;
                        inst_id  <= INST_NOP;
                        pc_id    <= '0;
                        id_valid <= 1'b0;
                        state    <= ST_DROP;
                    end else if (if_en) begin
                        inst_id  <= INST_NOP;
                        pc_id    <= '0;
                        id_valid <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (redirect) begin
                        pc       <= target;
                        inst_id  <= INST_NOP;
                        pc_id    <= '0;
                        id_valid <= 1'b0;
                        state    <= ST_REQ;
                    end else if (if_en) begin
                        inst_id  <= hold_inst;
                        pc_id    <= pc;
                        id_valid <= 1'b1;
                        pc       <= pc + 32'd4;
                        state    <= ST_REQ;
                    end
                end
                ST_DROP: begin
                    if (if_en) begin
                        inst_id  <= INST_NOP;
                        pc_id    <= '0;
                        id_valid <= 1'b0;
                    end
                    if (inst_ack) begin
                        pc    <= pend_pc;
                        state <= ST_REQ;
                    end
                end
                default: state <= ST_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: sequential fetch, redirects, late ack, stall, reset.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_if_stage;
    import if_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_rst;
    logic        if_en;
    logic [1:0]  pc_src;
    logic [31:0] rs_data_id;
    logic        inst_ren;
    logic [31:0] inst_addr;
    logic        inst_ack;
    logic [31:0] inst_data;
    logic [31:0] inst_id;
    logic [31:0] pc_id;
    logic        id_valid;
    logic        if_valid;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    if_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .if_rst     (if_rst),
        .if_en      (if_en),
        .pc_src     (pc_src),
        .rs_data_id (rs_data_id),
        .inst_ren   (inst_ren),
        .inst_addr  (inst_addr),
        .inst_ack   (inst_ack),
        .inst_data  (inst_data),
        .inst_id    (inst_id),
        .pc_id      (pc_id),
        .id_valid   (id_valid),
        .if_valid   (if_valid)
    );

    // Instruction memory image: a few planted instructions, addiu-like filler elsewhere.
    function automatic logic [31:0] imem(input logic [31:0] a);
        case (a)
            32'h0000_0010: imem = 32'h1000_0003;   // beq  +3
            32'h1000_0008: imem = 32'h0800_0040;   // j    0x40
            32'h0000_0200: imem = 32'h1000_0010;   // beq  +16
            32'h0000_0244: imem = 32'h8C22_0004;   // lw
            default:       imem = {16'h2400, a[15:0]};
        endcase
    endfunction

    always_comb inst_data = imem(inst_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; if_rst = 1'b0; if_en = 1'b1; pc_src = PC_NEXT;
        rs_data_id = '0; inst_ack = 1'b1;
        step(); step();
        check("rst_addr",    inst_addr, 32'h0);
        check("rst_ren",     {31'd0, inst_ren}, 32'd1);
        check("rst_idv",     {31'd0, id_valid}, 32'd0);
        check("rst_inst",    inst_id, 32'h0);
        check("rst_pcid",    pc_id, 32'h0);
        check("rst_ifv",     {31'd0, if_valid}, 32'd1);

        // sequential fetch with zero-wait memory
        rst = 1'b0;
        step();
        check("seq_addr4",   inst_addr, 32'h4);
        check("seq_pcid0",   pc_id, 32'h0);
        check("seq_idv",     {31'd0, id_valid}, 32'd1);
        check("seq_inst0",   inst_id, 32'h2400_0000);
        step();
        check("seq_addr8",   inst_addr, 32'h8);
        check("seq_pcid4",   pc_id, 32'h4);
        step();
        check("seq_addrC",   inst_addr, 32'hC);
        check("seq_pcid8",   pc_id, 32'h8);
        step();
        check("seq_addr10",  inst_addr, 32'h10);
        step();
        check("beq_inst",    inst_id, 32'h1000_0003);
        check("beq_pcid",    pc_id, 32'h10);
        check("beq_addr14",  inst_addr, 32'h14);

        // taken branch: 0x10+4+0xC
        pc_src = PC_BRANCH;
        step();
        check("br_addr",     inst_addr, 32'h20);
        check("br_bubble",   {31'd0, id_valid}, 32'd0);
        check("br_nop",      inst_id, 32'h0);
        pc_src = PC_NEXT;
        step();
        check("br_pcid",     pc_id, 32'h20);
        check("br_idv",      {31'd0, id_valid}, 32'd1);

        // JR to the jump instruction, then J, then JR with misaligned rs
        pc_src = PC_JR; rs_data_id = 32'h1000_000B;
        step();
        check("jr1_addr",    inst_addr, 32'h1000_0008);
        pc_src = PC_NEXT;
        step();
        check("j_inst",      inst_id, 32'h0800_0040);
        check("j_pcid",      pc_id, 32'h1000_0008);
        pc_src = PC_JUMP;
        step();
        check("j_addr",      inst_addr, 32'h1000_0100);
        pc_src = PC_NEXT;
        step();
        check("j_pcid2",     pc_id, 32'h1000_0100);
        pc_src = PC_JR; rs_data_id = 32'h0000_0203;
        step();
        check("jr2_addr",    inst_addr, 32'h200);
        pc_src = PC_NEXT;
        step();
        check("lat_inst",    inst_id, 32'h1000_0010);
        check("lat_addr",    inst_addr, 32'h204);

        // late ack: redirect in first wait cycle, ack arrives 3 cycles later
        inst_ack = 1'b0; pc_src = PC_BRANCH;
        step();
        check("drop_addr1",  inst_addr, 32'h204);
        check("drop_ifv1",   {31'd0, if_valid}, 32'd0);
        check("drop_ren1",   {31'd0, inst_ren}, 32'd1);
        check("drop_idv1",   {31'd0, id_valid}, 32'd0);
        pc_src = PC_NEXT;
        step();
        check("drop_addr2",  inst_addr, 32'h204);
        check("drop_ifv2",   {31'd0, if_valid}, 32'd0);
        step();
        check("drop_addr3",  inst_addr, 32'h204);
        inst_ack = 1'b1;
        step();
        check("drop_tgt",    inst_addr, 32'h244);
        check("drop_ifv4",   {31'd0, if_valid}, 32'd1);
        check("drop_idv4",   {31'd0, id_valid}, 32'd0);

        // stall while ack arrives: data parked, no refetch
        if_en = 1'b0;
        step();
        check("hold_ren1",   {31'd0, inst_ren}, 32'd0);
        check("hold_idv1",   {31'd0, id_valid}, 32'd0);
        step();
        check("hold_ren2",   {31'd0, inst_ren}, 32'd0);
        check("hold_addr",   inst_addr, 32'h244);
        if_en = 1'b1;
        step();
        check("hold_inst",   inst_id, 32'h8C22_0004);
        check("hold_pcid",   pc_id, 32'h244);
        check("hold_next",   inst_addr, 32'h248);
        check("hold_ren3",   {31'd0, inst_ren}, 32'd1);

        // reset while in DROP with a pending target of 0x40
        inst_ack = 1'b0; pc_src = PC_JR; rs_data_id = 32'h0000_0040;
        step();
        check("d2_ifv",      {31'd0, if_valid}, 32'd0);
        pc_src = PC_NEXT; rst = 1'b1;
        step();
        check("r2_addr",     inst_addr, 32'h0);
        check("r2_idv",      {31'd0, id_valid}, 32'd0);
        check("r2_ifv",      {31'd0, if_valid}, 32'd1);

        // pc_src ignored while ID holds a bubble
        rst = 1'b0; inst_ack = 1'b1; pc_src = PC_JR; rs_data_id = 32'h0000_0123;
        step();
        check("ign_addr",    inst_addr, 32'h4);
        check("ign_idv",     {31'd0, id_valid}, 32'd1);

        // wrap of the fetch address
        rs_data_id = 32'hFFFF_FFFF;
        step();
        check("wrap_req",    inst_addr, 32'hFFFF_FFFC);
        pc_src = PC_NEXT;
        step();
        check("wrap_addr",   inst_addr, 32'h0);
        check("wrap_pcid",   pc_id, 32'hFFFF_FFFC);
        check("wrap_inst",   inst_id, 32'h2400_FFFC);

        // controller stage reset
        if_rst = 1'b1;
        step();
        check("ifr_addr",    inst_addr, 32'h0);
        check("ifr_idv",     {31'd0, id_valid}, 32'd0);
        if_rst = 1'b0;
        step();
        check("ifr_run",     inst_addr, 32'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
